// File: rtl/maple_rx_framer.sv
// Maple frame parser between the Maple receiver and the FX2 slave-FIFO bridge.
// Optional feature macro: MAPLE_STATUS_BYTE_EN (append a status byte to every packet).
module maple_rx_framer #(
    parameter int MAX_WORDS = 255,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_busy,
    input  logic             i_rx_write,
    input  logic [7:0]       i_rx_data,
    output logic             o_out_write,
    output logic [7:0]       o_out_data,
    output logic             o_out_last,
    output logic             o_out_abort,
    output logic             o_frame_ok,
    output logic             o_frame_err,
    output logic [3:0]       o_err_code,
    output logic [CNT_W-1:0] o_frame_count,
    output logic [CNT_W-1:0] o_err_count
);

    // state   | meaning
    // IDLE    | waiting for rx_busy
    // HEADER  | collecting length, src, dst, cmd
    // PAYLOAD | collecting length*4 payload bytes
    // CHECK   | comparing the checksum byte
    // DRAIN   | dropping surplus bytes until rx_busy falls
    // STATUS  | one-cycle status report
    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_PAYLOAD, S_CHECK, S_DRAIN, S_STATUS
    } state_t;

    localparam logic [7:0] LP_MAX = 8'(MAX_WORDS);

    state_t           r_state;
    logic [1:0]       r_hdr_idx;
    logic [7:0]       r_len;
    logic [9:0]       r_cnt;
    logic [7:0]       r_acc;
    logic [3:0]       r_err;
    logic             r_out_write;
    logic [7:0]       r_out_data;
    logic             r_out_last;
    logic             r_out_abort;
    logic             r_frame_ok;
    logic             r_frame_err;
    logic [CNT_W-1:0] r_frame_count;
    logic [CNT_W-1:0] r_err_count;

    state_t           w_byte_next;
    logic             w_fwd;
    logic [3:0]       w_err_set;
    logic             w_short;
`ifndef MAPLE_STATUS_BYTE_EN
    logic             w_last;
`endif

    // Effect of the current rx byte, before considering rx_busy falling.
    always_comb begin
        w_byte_next = r_state;
        w_fwd       = 1'b0;
        w_err_set   = 4'b0000;
`ifndef MAPLE_STATUS_BYTE_EN
        w_last      = 1'b0;
`endif
        if (i_rx_write) begin
            case (r_state)
                S_HEADER: begin
                    w_fwd = 1'b1;
                    if (r_hdr_idx == 2'd3) begin
                        if (r_len == 8'd0) begin
                            w_byte_next = S_CHECK;
                        end else if (r_len > LP_MAX) begin
                            w_byte_next  = S_DRAIN;
                            w_err_set[3] = 1'b1;
                        end else begin
                            w_byte_next = S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    w_fwd = 1'b1;
                    if (r_cnt == 10'd1) w_byte_next = S_CHECK;
                end
                S_CHECK: begin
                    w_fwd       = 1'b1;
                    w_byte_next = S_DRAIN;
`ifndef MAPLE_STATUS_BYTE_EN
                    w_last      = 1'b1;
`endif
                    if (i_rx_data != r_acc) w_err_set[2] = 1'b1;
                end
                S_DRAIN: begin
                    // surplus bytes after an overlength header are expected, not "long"
                    if (!r_err[3]) w_err_set[1] = 1'b1;
                end
                default: ;
            endcase
        end
        w_short = !i_rx_busy && (w_byte_next != S_DRAIN) &&
                  ((r_state == S_HEADER) || (r_state == S_PAYLOAD) || (r_state == S_CHECK));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_hdr_idx     <= 2'd0;
            r_len         <= 8'd0;
            r_cnt         <= 10'd0;
            r_acc         <= 8'd0;
            r_err         <= 4'd0;
            r_out_write   <= 1'b0;
            r_out_data    <= 8'd0;
            r_out_last    <= 1'b0;
            r_out_abort   <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_count <= '0;
            r_err_count   <= '0;
        end else begin
            r_out_write <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_abort <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_fwd) begin
                r_out_write <= 1'b1;
                r_out_data  <= i_rx_data;
`ifndef MAPLE_STATUS_BYTE_EN
                r_out_last  <= w_last;
`endif
            end
            case (r_state)
                S_IDLE: begin
                    if (i_rx_busy) begin
                        r_state   <= S_HEADER;
                        r_acc     <= 8'd0;
                        r_err     <= 4'd0;
                        r_hdr_idx <= 2'd0;
                    end
                end
                S_STATUS: begin
                    r_state <= S_IDLE;
                    if (r_err == 4'd0) begin
                        r_frame_ok <= 1'b1;
                        if (r_frame_count != {CNT_W{1'b1}}) r_frame_count <= r_frame_count + 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                        if (r_err_count != {CNT_W{1'b1}}) r_err_count <= r_err_count + 1'b1;
                    end
`ifdef MAPLE_STATUS_BYTE_EN
                    r_out_write <= 1'b1;
                    r_out_last  <= 1'b1;
                    r_out_data  <= {4'b0000, r_err};
`else
                    r_out_abort <= r_err[0] | r_err[3];
`endif
                end
                default: begin
                    if (i_rx_write && (r_state == S_HEADER)) begin
                        r_acc     <= r_acc ^ i_rx_data;
                        r_hdr_idx <= r_hdr_idx + 2'd1;
                        if (r_hdr_idx == 2'd0) r_len <= i_rx_data;
                        if (r_hdr_idx == 2'd3) r_cnt <= {r_len, 2'b00};
                    end
                    if (i_rx_write && (r_state == S_PAYLOAD)) begin
                        r_acc <= r_acc ^ i_rx_data;
                        r_cnt <= r_cnt - 10'd1;
                    end
                    r_err   <= r_err | w_err_set | {3'b000, w_short};
                    r_state <= i_rx_busy ? w_byte_next : S_STATUS;
                end
            endcase
        end
    end

    assign o_out_write   = r_out_write;
    assign o_out_data    = r_out_data;
    assign o_out_last    = r_out_last;
    assign o_out_abort   = r_out_abort;
    assign o_frame_ok    = r_frame_ok;
    assign o_frame_err   = r_frame_err;
    assign o_err_code    = r_err;
    assign o_frame_count = r_frame_count;
    assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_maple_rx_framer.sv
// Scoreboard bench for maple_rx_framer (MAX_WORDS=2); honours MAPLE_STATUS_BYTE_EN.
module tb_maple_rx_framer;

`ifdef MAPLE_STATUS_BYTE_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_busy = 1'b0;
    logic        rx_write = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        out_write, out_last, out_abort, frame_ok, frame_err;
    logic [7:0]  out_data;
    logic [3:0]  err_code;
    logic [15:0] frame_count, err_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] q_byte[$];   // {last, data}
    logic [6:0] q_stat[$];   // {abort, ok, err, code}

    maple_rx_framer #(.MAX_WORDS(2), .CNT_W(16)) dut (
        .i_clk(clk), .i_reset(reset), .i_rx_busy(rx_busy), .i_rx_write(rx_write),
        .i_rx_data(rx_data), .o_out_write(out_write), .o_out_data(out_data),
        .o_out_last(out_last), .o_out_abort(out_abort), .o_frame_ok(frame_ok),
        .o_frame_err(frame_err), .o_err_code(err_code), .o_frame_count(frame_count),
        .o_err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (out_write) begin
                n_cmp++;
                if (q_byte.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_byte: unexpected byte %02h last=%0b", out_data, out_last);
                end else begin
                    logic [8:0] e;
                    e = q_byte.pop_front();
                    if ({out_last, out_data} !== e) begin
                        n_bad++;
                        $display("FAIL out_byte: got last=%0b data=%02h, want last=%0b data=%02h",
                                 out_last, out_data, e[8], e[7:0]);
                    end
                end
            end
            if (frame_ok || frame_err) begin
                n_cmp++;
                if (q_stat.size() == 0) begin
                    n_bad++;
                    $display("FAIL status: unexpected pulse ok=%0b err=%0b code=%04b",
                             frame_ok, frame_err, err_code);
                end else begin
                    logic [6:0] s;
                    s = q_stat.pop_front();
                    if ({out_abort, frame_ok, frame_err, err_code} !== s) begin
                        n_bad++;
                        $display("FAIL status: got abort=%0b ok=%0b err=%0b code=%04b, want abort=%0b ok=%0b err=%0b code=%04b",
                                 out_abort, frame_ok, frame_err, err_code, s[6], s[5], s[4], s[3:0]);
                    end
                end
            end else if (out_abort) begin
                n_cmp++;
                n_bad++;
                $display("FAIL abort: out_abort=1 without a status pulse");
            end
        end
    end

    task automatic put(input logic [7:0] b, input bit fwd, input bit last);
        if (fwd) q_byte.push_back({last & !SB, b});
        @(posedge clk); #1;
        rx_write = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_write = 1'b0;
    endtask

    task automatic begin_frame();
        @(posedge clk); #1;
        rx_busy = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q_byte.size() == 0 && q_stat.size() == 0) break;
        end
        n_cmp++;
        if (i == 40) begin
            n_bad++;
            $display("FAIL %s_timeout: %0d bytes and %0d statuses outstanding, want 0",
                     name, q_byte.size(), q_stat.size());
            q_byte.delete();
            q_stat.delete();
        end
    endtask

    task automatic end_frame(input logic [3:0] code, input string name);
        bit ok;
        ok = (code == 4'd0);
        q_stat.push_back({!SB && (code[0] || code[3]), ok, !ok, code});
        if (SB) q_byte.push_back({1'b1, 4'b0000, code});
        @(posedge clk); #1;
        rx_busy = 1'b0;
        wait_drain(name);
    endtask

    task automatic send_frame1(input logic [7:0] csum);
        logic [7:0] b[8] = '{8'h01, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int k = 0; k < 8; k++) put(b[k], 1'b1, 1'b0);
        put(csum, 1'b1, 1'b1);
    endtask

    task automatic check_counts(input string name, input int fc, input int ec);
        n_cmp++;
        if (frame_count !== 16'(fc) || err_count !== 16'(ec)) begin
            n_bad++;
            $display("FAIL %s_counts: got frame_count=%0d err_count=%0d, want %0d %0d",
                     name, frame_count, err_count, fc, ec);
        end
    endtask

    task automatic check_code(input string name, input logic [3:0] code);
        n_cmp++;
        if (err_code !== code) begin
            n_bad++;
            $display("FAIL %s_code: got err_code=%04b, want %04b", name, err_code, code);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({out_write, out_data, out_last, out_abort, frame_ok, frame_err, err_code} !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got wr=%0b data=%02h last=%0b abort=%0b ok=%0b err=%0b code=%04b, want all 0",
                     out_write, out_data, out_last, out_abort, frame_ok, frame_err, err_code);
        end
        check_counts("reset", 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_good();
        begin_frame();
        send_frame1(8'h20);
        end_frame(4'b0000, "good");
        check_code("good", 4'b0000);
        check_counts("good", 1, 0);
    endtask

    task automatic test_bad_csum();
        begin_frame();
        send_frame1(8'h21);
        end_frame(4'b0100, "csum");
        check_code("csum", 4'b0100);
        check_counts("csum", 1, 1);
    endtask

    task automatic test_short();
        logic [7:0] b[5] = '{8'h01, 8'h20, 8'h00, 8'h01, 8'hAA};
        begin_frame();
        for (int k = 0; k < 5; k++) put(b[k], 1'b1, 1'b0);
        end_frame(4'b0001, "short");
        check_code("short", 4'b0001);
        check_counts("short", 1, 2);
    endtask

    task automatic test_long();
        begin_frame();
        send_frame1(8'h20);
        put(8'h55, 1'b0, 1'b0);
        end_frame(4'b0010, "long");
        check_code("long", 4'b0010);
        check_counts("long", 1, 3);
    endtask

    task automatic test_overlen();
        logic [7:0] h[4] = '{8'h03, 8'h20, 8'h00, 8'h01};
        begin_frame();
        for (int k = 0; k < 4; k++) put(h[k], 1'b1, 1'b0);
        for (int k = 0; k < 13; k++) put(8'(8'h40 + k), 1'b0, 1'b0);
        end_frame(4'b1000, "overlen");
        check_code("overlen", 4'b1000);
        check_counts("overlen", 1, 4);
    endtask

    task automatic test_ignore();
        for (int k = 0; k < 3; k++) put(8'hE0 + 8'(k), 1'b0, 1'b0);
        wait_drain("ignore");
        check_counts("ignore", 1, 4);
    endtask

    task automatic test_back_to_back();
        logic [7:0] z[4] = '{8'h00, 8'h20, 8'h00, 8'h01};
        logic [7:0] m[12] = '{8'h02, 8'h20, 8'h00, 8'h01, 8'h11, 8'h12,
                              8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        begin_frame();
        for (int k = 0; k < 4; k++) put(z[k], 1'b1, 1'b0);
        put(8'h21, 1'b1, 1'b1);
        end_frame(4'b0000, "len0");
        begin_frame();
        for (int k = 0; k < 12; k++) put(m[k], 1'b1, 1'b0);
        put(8'h2B, 1'b1, 1'b1);
        end_frame(4'b0000, "lenmax");
        check_code("lenmax", 4'b0000);
        check_counts("back_to_back", 3, 4);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b[5] = '{8'h01, 8'h20, 8'h00, 8'h01, 8'hAA};
        begin_frame();
        for (int k = 0; k < 5; k++) put(b[k], 1'b1, 1'b0);
        @(posedge clk); #1;
        reset   = 1'b1;
        rx_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_counts("midreset", 0, 0);
        begin_frame();
        send_frame1(8'h20);
        end_frame(4'b0000, "after_reset");
        check_counts("after_reset", 1, 0);
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_csum();
        test_short();
        test_long();
        test_overlen();
        test_ignore();
        test_back_to_back();
        test_reset_midframe();
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
